// File: rtl/huff_sched.sv
// huff_sched: two-requester frame scheduler in front of a shared huffman encoder.
// Arbitrates req0/req1 round-robin, pulses core_rst to clear the encoder,
// forwards the owner's gray pixels with one cycle of latency, then waits for
// the encoder's CNT_valid/code_valid status (bounded by TIMEOUT) and reports
// completion.
//   clk, reset                    clock, async active-high reset
//   req*/px_valid*/px_data*/px_last*   requester frame and pixel inputs
//   gnt0/gnt1                     owner grant, high only while streaming
//   core_rst, gray_valid, gray_data    encoder-side control and pixel stream
//   CNT_valid, code_valid         encoder status
//   busy, done_valid, done_id, done_err   scheduler status / completion report
module huff_sched #(
  parameter logic [7:0] MAX_PIX = 8'd200,
  parameter logic [9:0] TIMEOUT = 10'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       px_valid0,
  input  logic       px_valid1,
  input  logic [7:0] px_data0,
  input  logic [7:0] px_data1,
  input  logic       px_last0,
  input  logic       px_last1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       core_rst,
  output logic       gray_valid,
  output logic [7:0] gray_data,
  input  logic       CNT_valid,
  input  logic       code_valid,
  output logic       busy,
  output logic       done_valid,
  output logic       done_id,
  output logic [1:0] done_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLR       = 3'd1,
    STREAM    = 3'd2,
    WAIT_CNT  = 3'd3,
    WAIT_CODE = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic       owner, last_srv, served;
  logic [7:0] pix_cnt;
  logic [9:0] tmo_cnt;
  logic       ovf, tmo;

  logic       sel_valid, sel_last, winner, accept, tmo_hit, pix_end;
  logic [7:0] sel_data;

  always_comb begin
    sel_valid = owner ? px_valid1 : px_valid0;
    sel_data  = owner ? px_data1  : px_data0;
    sel_last  = owner ? px_last1  : px_last0;
    accept    = (state == STREAM) && sel_valid;
    pix_end   = sel_last || (pix_cnt + 8'd1 == MAX_PIX);
    // tmo_cnt reaches TIMEOUT on the same edge the FSM enters DONE.
    tmo_hit   = ((state == WAIT_CNT) || (state == WAIT_CODE)) &&
                (tmo_cnt + 10'd1 == TIMEOUT);
    // Before any frame has been served, requester 0 wins a tie.
    if (req0 && req1) winner = served ? ~last_srv : 1'b0;
    else              winner = req1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (req0 || req1) state_nxt = CLR;
      CLR:       state_nxt = STREAM;
      STREAM:    if (accept && pix_end) state_nxt = WAIT_CNT;
      WAIT_CNT:  if (tmo_hit) state_nxt = DONE;
                 else if (CNT_valid) state_nxt = WAIT_CODE;
      WAIT_CODE: if (tmo_hit || code_valid) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0       = (state == STREAM) && !owner;
    gnt1       = (state == STREAM) && owner;
    core_rst   = (state == CLR);
    busy       = (state != IDLE);
    done_valid = (state == DONE);
    done_id    = (state == DONE) && owner;
    done_err   = (state == DONE) ? {ovf, tmo} : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_srv   <= 1'b0;
      served     <= 1'b0;
      pix_cnt    <= '0;
      tmo_cnt    <= '0;
      ovf        <= 1'b0;
      tmo        <= 1'b0;
      gray_valid <= 1'b0;
      gray_data  <= '0;
    end else begin
      state      <= state_nxt;
      gray_valid <= accept;
      if (accept) gray_data <= sel_data;
      unique case (state)
        IDLE: if (req0 || req1) owner <= winner;
        CLR: begin
          pix_cnt <= '0;
          ovf     <= 1'b0;
          tmo     <= 1'b0;
        end
        STREAM: begin
          // Held at zero while streaming so it is clear on entry to WAIT_CNT.
          tmo_cnt <= '0;
          if (accept) begin
            pix_cnt <= pix_cnt + 8'd1;
            if (!sel_last && (pix_cnt + 8'd1 == MAX_PIX)) ovf <= 1'b1;
          end
        end
        WAIT_CNT, WAIT_CODE: begin
          tmo_cnt <= tmo_cnt + 10'd1;
          if (tmo_hit) tmo <= 1'b1;
        end
        DONE: begin
          last_srv <= owner;
          served   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_sched.sv
// tb_huff_sched: directed plus randomized frames against a transaction-level
// model of the scheduler (arbitration, forwarding, overflow, timeout, reset).
module tb_huff_sched;

  localparam int MAXP = 4;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, px_valid0, px_valid1, px_last0, px_last1;
  logic [7:0] px_data0, px_data1;
  logic       gnt0, gnt1, core_rst, gray_valid;
  logic [7:0] gray_data;
  logic       CNT_valid, code_valid;
  logic       busy, done_valid, done_id;
  logic [1:0] done_err;

  int   total = 0;
  int   bad   = 0;
  bit   served_m, last_m;
  logic [7:0] pat [0:3];

  always #5 clk = ~clk;

  huff_sched #(.MAX_PIX(8'd4), .TIMEOUT(10'd20)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .px_valid0(px_valid0), .px_valid1(px_valid1),
    .px_data0(px_data0), .px_data1(px_data1),
    .px_last0(px_last0), .px_last1(px_last1),
    .gnt0(gnt0), .gnt1(gnt1), .core_rst(core_rst),
    .gray_valid(gray_valid), .gray_data(gray_data),
    .CNT_valid(CNT_valid), .code_valid(code_valid),
    .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_err(done_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {gnt0, gnt1, core_rst, gray_valid, gray_data, busy, done_valid, done_id, done_err};
  endfunction

  task automatic clear_inputs();
    req0 = 0; req1 = 0;
    px_valid0 = 0; px_valid1 = 0; px_last0 = 0; px_last1 = 0;
    px_data0 = '0; px_data1 = '0;
    CNT_valid = 0; code_valid = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    clear_inputs();
    @(negedge clk);
    chk("rst_pulse_outs", 32'(all_outs()), 0);
    reset = 0;
    served_m = 0;
    last_m   = 0;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  // mode: 0 status answered, 1 code never arrives, 2 CNT+code together first.
  task automatic run_frame(input bit r0, input bit r1, input int npix,
                           input bit with_last, input int mode, input bit use_pat,
                           input bit drop_req, input int abort_at);
    bit own, egv, ovf_m, tmo_m, v, l, cin, kin;
    logic [7:0] egd, d;
    int cnt, pi, w, phase, guard, ngv, dc, exp_acc;
    cnt = 0; pi = 0; w = 0; phase = 0; guard = 0; ngv = 0;
    egv = 0; ovf_m = 0; tmo_m = 0; egd = '0;
    dc = $urandom_range(0, 6);
    exp_acc = (with_last && npix <= MAXP) ? npix : MAXP;

    chk("idle_busy", busy, 0);
    req0 = r0; req1 = r1;
    own = (r0 && r1) ? (served_m ? !last_m : 1'b0) : r1;

    @(negedge clk);
    chk("clr_core_rst", core_rst, 1);
    chk("clr_busy", busy, 1);
    chk("clr_gnt", {gnt0, gnt1}, 0);
    chk("clr_gray_valid", gray_valid, 0);
    // Owner pixel during CLR must not be forwarded.
    if (own) begin px_valid1 = 1; px_data1 = 8'hA5; end
    else     begin px_valid0 = 1; px_data0 = 8'hA5; end
    if (drop_req) begin
      if (own) req1 = 0; else req0 = 0;
    end

    forever begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("frame_bound", phase, 3);
        clear_inputs();
        return;
      end
      chk("gray_valid", gray_valid, egv);
      if (egv) chk("gray_data", gray_data, egd);
      if (gray_valid) ngv++;
      chk("gnt0", gnt0, (phase == 0) && !own);
      chk("gnt1", gnt1, (phase == 0) && own);
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("core_rst_low", core_rst, 0);
      chk("done_valid", done_valid, phase == 3);
      if (phase == 3) begin
        chk("done_id", done_id, own);
        chk("done_err", done_err, {ovf_m, tmo_m});
        if (tmo_m) chk("tmo_latency", w, TMO);
        chk("gv_pulses", ngv, exp_acc);
        break;
      end
      chk("busy", busy, 1);

      if (abort_at > 0 && pi == abort_at && phase == 0) begin
        reset = 1;
        clear_inputs();
        @(negedge clk);
        chk("abort_outs", 32'(all_outs()), 0);
        reset = 0;
        @(negedge clk);
        chk("abort_no_done", done_valid, 0);
        chk("abort_idle", busy, 0);
        served_m = 0;
        last_m   = 0;
        return;
      end

      v = (pi < npix) && ($urandom_range(0, 3) != 0);
      d = use_pat ? pat[pi % 4] : 8'($urandom);
      l = v && with_last && (pi == npix - 1);
      if (v) pi++;
      if (own) begin
        px_valid1 = v; px_data1 = d; px_last1 = l;
        px_valid0 = 1'($urandom); px_data0 = 8'($urandom); px_last0 = 1'($urandom);
      end else begin
        px_valid0 = v; px_data0 = d; px_last0 = l;
        px_valid1 = 1'($urandom); px_data1 = 8'($urandom); px_last1 = 1'($urandom);
      end
      if (phase == 0) begin
        cin = 1'($urandom);
        kin = 1'($urandom);
      end else begin
        case (mode)
          1:       begin cin = (w >= dc); kin = 0; end
          2:       begin cin = (w == dc); kin = (w == dc) || (w >= dc + 3); end
          default: begin cin = (w >= dc); kin = ($urandom_range(0, 2) == 0); end
        endcase
      end
      CNT_valid = cin; code_valid = kin;

      egv = 0;
      if (phase == 0) begin
        if (v) begin
          egv = 1; egd = d; cnt++;
          if (l) begin phase = 1; w = 0; end
          else if (cnt == MAXP) begin ovf_m = 1; phase = 1; w = 0; end
        end
      end else begin
        if (w + 1 == TMO) begin tmo_m = 1; phase = 3; end
        else if (phase == 1 && cin) phase = 2;
        else if (phase == 2 && kin) phase = 3;
        w++;
      end
    end

    // DONE cycle: drop requests, throw stray status at the idle block.
    clear_inputs();
    CNT_valid = 1'($urandom); code_valid = 1'($urandom);
    last_m = own;
    served_m = 1;
    @(negedge clk);
    chk("post_done_valid", done_valid, 0);
    chk("post_done_busy", busy, 0);
    chk("post_done_core_rst", core_rst, 0);
  endtask

  initial begin
    bit r0, r1, wl;
    int np;
    reset = 1;
    clear_inputs();
    pat[0] = 8'd1; pat[1] = 8'd2; pat[2] = 8'd3; pat[3] = 8'd3;
    served_m = 0; last_m = 0;
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'(all_outs()), 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_outs", 32'(all_outs()), 0);

    run_frame(1, 0, 4, 1, 0, 1, 0, 0);          // single frame 1,2,3,3

    pulse_reset();
    for (int i = 0; i < 4; i++)                 // contention 0,1,0,1
      run_frame(1, 1, $urandom_range(1, 4), 1, 0, 0, 0, 0);

    run_frame(0, 1, 6, 0, 0, 0, 0, 0);          // overflow
    run_frame(1, 0, 3, 1, 1, 0, 0, 0);          // timeout
    run_frame(0, 1, 2, 1, 2, 0, 0, 0);          // simultaneous status
    run_frame(1, 1, 3, 1, 0, 0, 1, 0);          // req dropped mid-frame
    run_frame(1, 0, 5, 1, 0, 0, 0, 2);          // reset after 2 pixels
    run_frame(1, 1, 3, 1, 0, 0, 0, 0);          // tie after reset -> 0

    for (int i = 0; i < 30; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      wl = 1'($urandom);
      np = wl ? $urandom_range(1, 6) : $urandom_range(MAXP, MAXP + 3);
      run_frame(r0, r1, np, wl, $urandom_range(0, 2), 0, 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huff_sched.md
HUFF_SCHED -- requirements
Module: huff_sched

Interface
REQ-001 Parameter MAX_PIX, default 8'd200, maximum pixels forwarded per frame.
REQ-002 Parameter TIMEOUT, default 10'd1000, cycles allowed from the last forwarded pixel to core code_valid.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-004 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 req0, req1  in  1 each  frame request from requester 0 and requester 1.
REQ-007 px_valid0, px_valid1  in  1 each  pixel valid from each requester.
REQ-008 px_data0, px_data1  in  8 each  gray pixel from each requester.
REQ-009 px_last0, px_last1  in  1 each  marks the final pixel of a frame, qualified by px_valid.
REQ-010 gnt0, gnt1  out  1 each  requester owns the encoder; at most one SHALL be high.
REQ-011 core_rst  out  1  reset pulse to the shared huffman encoder.
REQ-012 gray_valid  out  1  pixel strobe to the encoder.
REQ-013 gray_data  out  8  pixel to the encoder.
REQ-014 CNT_valid, code_valid  in  1 each  status from the encoder.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done_valid  out  1  one-cycle frame-completion pulse.
REQ-017 done_id  out  1  requester served by the completed frame.
REQ-018 done_err  out  2  completion status: bit0 timeout, bit1 MAX_PIX overflow.

Function
REQ-019 The FSM SHALL have the states IDLE, CLR, STREAM, WAIT_CNT, WAIT_CODE and DONE, encoded in 3 bits.
REQ-020 IDLE: if req0 or req1 is high, the block SHALL latch the winner into owner and move to CLR. Round-robin: a requester that differs from the last served wins; after reset, requester 0 wins a tie.
REQ-021 CLR: core_rst SHALL be high for exactly 1 cycle, then the FSM SHALL move to STREAM.
REQ-022 The gnt output for owner SHALL be high in STREAM only.
REQ-023 STREAM: gray_valid and gray_data SHALL be registered copies of the owner's px_valid and px_data, with 1-cycle latency.
REQ-024 The non-owner's pixel inputs SHALL be ignored.
REQ-025 The 8-bit pix_cnt SHALL clear in CLR and increment on each accepted owner pixel.
REQ-026 STREAM SHALL exit to WAIT_CNT on an accepted pixel with px_last high; that pixel is still forwarded.
REQ-027 When pix_cnt reaches MAX_PIX without px_last, the FSM SHALL move to WAIT_CNT and set the ovf flag. Later owner pixels are dropped.
REQ-028 gray_valid SHALL be 0 in every state other than the cycle after an accepted pixel.
REQ-029 WAIT_CNT: on CNT_valid high, the FSM SHALL move to WAIT_CODE.
REQ-030 WAIT_CODE: on code_valid high, the FSM SHALL move to DONE.
REQ-031 A 10-bit tmo_cnt SHALL clear on entry to WAIT_CNT and increment every cycle in WAIT_CNT and WAIT_CODE.
REQ-032 When tmo_cnt equals TIMEOUT, the FSM SHALL set the tmo flag and move to DONE.
REQ-033 If CNT_valid and code_valid arrive in the same cycle in WAIT_CNT, the FSM SHALL move to WAIT_CODE only.
REQ-034 Status arriving outside WAIT_CNT and WAIT_CODE SHALL be ignored.
REQ-035 DONE: done_valid SHALL be high for 1 cycle with done_id = owner and done_err = {ovf, tmo}.
REQ-036 In DONE the last-served pointer SHALL be set to owner, and the FSM SHALL return to IDLE.
REQ-037 Minimum gap from done_valid to the next core_rst SHALL be 2 cycles, through IDLE.
REQ-038 A requester dropping req mid-frame SHALL NOT abort the frame; the frame ends only by px_last, MAX_PIX or timeout.

Reset
REQ-039 On reset, the FSM SHALL go to IDLE.
REQ-040 On reset, all outputs SHALL be 0; core_rst is 0, and the encoder is reset only via CLR.
REQ-041 On reset, owner, the last-served pointer, pix_cnt, tmo_cnt, ovf and tmo SHALL be 0.
REQ-042 Reset asserted mid-frame SHALL abandon the frame with no done_valid.

Verification
REQ-043 Single frame: req0 with pixels 1,2,3,3 (last on 4th) -> one core_rst pulse, then gray_data 1,2,3,3 each 1 cycle after input; encoder status answered -> done_valid with done_id=0, done_err=0.
REQ-044 Contention: req0 and req1 high from reset -> served in the order 0,1,0,1; gnt0 and gnt1 never both high.
REQ-045 Overflow: MAX_PIX=4, six pixels without last -> exactly 4 gray_valid pulses; done_err=2'b10.
REQ-046 Timeout: TIMEOUT=20, code_valid never asserted -> done_valid 20 cycles after entering WAIT_CNT; done_err=2'b01.
REQ-047 Simultaneous status: CNT_valid and code_valid in the same cycle in WAIT_CNT -> WAIT_CODE entered; DONE only on a later code_valid.
REQ-048 Reset mid-STREAM after 2 pixels -> all outputs 0 next cycle; no done_valid; next frame starts with core_rst.
